// File: rtl/vlsi_stream_pkg.sv
// Shared types and defaults for the Wiener block write buffer.
package vlsi_stream_pkg;
   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam int unsigned DEFAULT_BLOCK_SIZE = 8;
   localparam int unsigned BLOCKS_W           = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } drain_state_t;
endpackage

// File: rtl/wiener_block_write_buffer_if.sv
// Pixel stream input plus burst start / AXI W-beat signals of the write buffer.
interface wiener_block_write_buffer_if import vlsi_stream_pkg::*; #(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;
   logic                  start_write_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  wvalid;
   logic                  wlast;

   modport slave (
      input  s_data, s_valid, wvalid, wlast,
      output s_ready, start_write_out, data_out
   );

   modport master (
      output s_data, s_valid, wvalid, wlast,
      input  s_ready, start_write_out, data_out
   );
endinterface

// File: rtl/dual_bank_buffer.sv
// Two-bank register file: one write port, one asynchronous read port, per-bank full flags.
module dual_bank_buffer import vlsi_stream_pkg::*; #(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
   localparam int unsigned IDX_W     = $clog2(BLOCK_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  wr_bank,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_bank,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  set_full,
   input  logic                  set_bank,
   input  logic                  clr_full,
   input  logic                  clr_bank,
   output logic [1:0]            full
);
   logic [DATA_WIDTH-1:0] mem_q [2][BLOCK_SIZE];
   logic [DATA_WIDTH-1:0] mem_d [2][BLOCK_SIZE];
   logic [1:0]            full_q;
   logic [1:0]            full_d;

   // Set and clear always target different banks, so both may act in one cycle.
   always_comb begin
      mem_d  = mem_q;
      full_d = full_q;
      if (wr_en)    mem_d[wr_bank][wr_idx] = wr_data;
      if (set_full) full_d[set_bank]       = 1'b1;
      if (clr_full) full_d[clr_bank]       = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q  <= '{default: '0};
         full_q <= '0;
      end else begin
         mem_q  <= mem_d;
         full_q <= full_d;
      end
   end

   assign rd_data = mem_q[rd_bank][rd_idx];
   assign full    = full_q;
endmodule

// File: rtl/wiener_block_write_buffer.sv
// Ping-pong buffer between the Wiener filter stream and the AXI memory writer:
// one bank fills from s_data while the other drains one pixel per W beat.
module wiener_block_write_buffer import vlsi_stream_pkg::*; #(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
   parameter int unsigned BW_INIT    = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   wiener_block_write_buffer_if.slave bus,
   output logic [BLOCKS_W-1:0]        blocks_written,
   output logic                       protocol_err
);
   localparam int unsigned      IDX_W    = $clog2(BLOCK_SIZE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   drain_state_t          state_q, state_d;
   logic                  fill_bank_q, fill_bank_d;
   logic                  rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
   logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
   logic [BLOCKS_W-1:0]   blocks_q, blocks_d;
   logic                  err_q, err_d;
   logic [1:0]            full;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  fill_xfer, fill_done, beat, drain_done;

   dual_bank_buffer #(.DATA_WIDTH(DATA_WIDTH), .BLOCK_SIZE(BLOCK_SIZE)) u_banks (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (fill_xfer),
      .wr_bank  (fill_bank_q),
      .wr_idx   (wr_idx_q),
      .wr_data  (bus.s_data),
      .rd_bank  (rd_bank_q),
      .rd_idx   (rd_idx_q),
      .rd_data  (rd_data),
      .set_full (fill_done),
      .set_bank (fill_bank_q),
      .clr_full (drain_done),
      .clr_bank (rd_bank_q),
      .full     (full)
   );

   // A bank under drain stays full until its last beat, so s_ready cannot rise for it.
   assign bus.s_ready = !rst && !full[fill_bank_q];
   assign fill_xfer   = bus.s_valid && bus.s_ready;
   assign beat        = bus.wvalid && (state_q == WAIT || state_q == DRAIN);

   always_comb begin
      fill_bank_d = fill_bank_q;
      wr_idx_d    = wr_idx_q;
      fill_done   = 1'b0;
      if (fill_xfer) begin
         if (wr_idx_q == LAST_IDX) begin
            fill_done   = 1'b1;
            fill_bank_d = !fill_bank_q;
            wr_idx_d    = '0;
         end else begin
            wr_idx_d = wr_idx_q + IDX_ONE;
         end
      end
   end

   // Beat handling; a burst ended early by wlast is still retired and counted.
   always_comb begin
      rd_bank_d  = rd_bank_q;
      rd_idx_d   = rd_idx_q;
      blocks_d   = blocks_q;
      err_d      = err_q;
      drain_done = 1'b0;
      if (bus.wvalid && (state_q == IDLE || state_q == START)) err_d = 1'b1;
      if (beat) begin
         if (bus.wlast) begin
            if (rd_idx_q != LAST_IDX) err_d = 1'b1;
            drain_done = 1'b1;
            rd_bank_d  = !rd_bank_q;
            rd_idx_d   = '0;
            blocks_d   = blocks_q + BLOCKS_W'(1);
         end else if (rd_idx_q == LAST_IDX) begin
            err_d = 1'b1;
         end else begin
            rd_idx_d = rd_idx_q + IDX_ONE;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:        if (full[rd_bank_q]) state_d = START;
         START:       state_d = bus.wvalid ? IDLE : WAIT;
         WAIT, DRAIN: if (bus.wvalid) state_d = bus.wlast ? IDLE : DRAIN;
         default:     state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.start_write_out = 1'b0;
      bus.data_out        = '0;
      case (state_q)
         START:       bus.start_write_out = 1'b1;
         WAIT, DRAIN: bus.data_out        = rd_data;
         default:     ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_bank_q <= 1'b0;
         wr_idx_q    <= '0;
         rd_bank_q   <= 1'b0;
         rd_idx_q    <= '0;
         blocks_q    <= BLOCKS_W'(BW_INIT);
         err_q       <= 1'b0;
      end else begin
         fill_bank_q <= fill_bank_d;
         wr_idx_q    <= wr_idx_d;
         rd_bank_q   <= rd_bank_d;
         rd_idx_q    <= rd_idx_d;
         blocks_q    <= blocks_d;
         err_q       <= err_d;
      end
   end

   assign blocks_written = blocks_q;
   assign protocol_err   = err_q;
endmodule

// File: tb/tb_wiener_block_write_buffer.sv
// Directed bench for the Wiener block write buffer; a second instance starts its
// burst counter near the top so wrap-around is reachable in a few bursts.
module tb_wiener_block_write_buffer;
   import vlsi_stream_pkg::*;

   localparam int unsigned DW = 32;

   logic          clk     = 1'b0;
   logic          rst     = 1'b1;
   logic [DW-1:0] s_data  = '0;
   logic          s_valid = 1'b0;
   logic          wvalid  = 1'b0;
   logic          wlast   = 1'b0;
   logic          s_ready, start_write_out, w_ready, w_start;
   logic [DW-1:0] data_out, w_data_out;
   logic [15:0]   blocks_written, w_blocks;
   logic          protocol_err, w_err;
   logic [DW-1:0] pix_tab [64];
   int            checks = 0;
   int            errors = 0;

   wiener_block_write_buffer_if #(.DATA_WIDTH(DW)) bus_m ();
   wiener_block_write_buffer_if #(.DATA_WIDTH(DW)) bus_w ();

   assign bus_m.s_data  = s_data;
   assign bus_m.s_valid = s_valid;
   assign bus_m.wvalid  = wvalid;
   assign bus_m.wlast   = wlast;
   assign bus_w.s_data  = s_data;
   assign bus_w.s_valid = s_valid;
   assign bus_w.wvalid  = wvalid;
   assign bus_w.wlast   = wlast;
   assign s_ready         = bus_m.s_ready;
   assign start_write_out = bus_m.start_write_out;
   assign data_out        = bus_m.data_out;
   assign w_ready         = bus_w.s_ready;
   assign w_start         = bus_w.start_write_out;
   assign w_data_out      = bus_w.data_out;

   wiener_block_write_buffer #(.DATA_WIDTH(DW), .BLOCK_SIZE(8)) u_dut (
      .clk(clk), .rst(rst), .bus(bus_m),
      .blocks_written(blocks_written), .protocol_err(protocol_err)
   );

   wiener_block_write_buffer #(.DATA_WIDTH(DW), .BLOCK_SIZE(8), .BW_INIT(32'hFFFE)) u_wrap (
      .clk(clk), .rst(rst), .bus(bus_w),
      .blocks_written(w_blocks), .protocol_err(w_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; s_valid = 1'b0; wvalid = 1'b0; wlast = 1'b0; s_data = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic fill_block(input int base);
      for (int j = 0; j < 8; j++) begin
         s_valid = 1'b1; s_data = pix_tab[base + j];
         tick();
      end
      s_valid = 1'b0;
   endtask

   task automatic drain_burst();
      for (int j = 0; j < 8; j++) begin
         wvalid = 1'b1; wlast = (j == 7);
         tick();
      end
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic wait_pulse(output bit ok);
      int k = 0;
      ok = 1'b0;
      while (!ok && k < 30) begin
         if (start_write_out === 1'b1) ok = 1'b1;
         else begin tick(); k++; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %0h want 0", s_ready); end
      checks++; if (start_write_out !== 1'b0) begin errors++; $display("FAIL rst_start: got %0h want 0", start_write_out); end
      checks++; if (data_out !== '0) begin errors++; $display("FAIL rst_data_out: got %0h want 0", data_out); end
      checks++; if (blocks_written !== 16'd0) begin errors++; $display("FAIL rst_blocks: got %0h want 0", blocks_written); end
      checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0h want 0", protocol_err); end
      checks++; if (w_blocks !== 16'hFFFE) begin errors++; $display("FAIL rst_wrap_init: got %0h want fffe", w_blocks); end
      rst = 1'b0;
      #1;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0h want 1", s_ready); end
      checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL rst_release_wready: got %0h want 1", w_ready); end
   endtask

   task automatic test_single_block();
      do_reset();
      for (int j = 0; j < 8; j++) begin
         s_valid = 1'b1; s_data = pix_tab[j];
         if (j == 0) begin
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL t1_ready: got %0h want 1", s_ready); end
         end
         tick();
      end
      s_valid = 1'b0;
      checks++; if (start_write_out !== 1'b0) begin errors++; $display("FAIL t1_pulse_n1: got %0h want 0", start_write_out); end
      tick();
      checks++; if (start_write_out !== 1'b1) begin errors++; $display("FAIL t1_pulse_n2: got %0h want 1", start_write_out); end
      tick();
      checks++; if (start_write_out !== 1'b0) begin errors++; $display("FAIL t1_pulse_width: got %0h want 0", start_write_out); end
      tick(); tick(); tick();
      for (int j = 0; j < 8; j++) begin
         wvalid = 1'b1; wlast = (j == 7);
         checks++; if (data_out !== pix_tab[j]) begin errors++; $display("FAIL t1_beat%0d: got %0d want %0d", j, data_out, pix_tab[j]); end
         tick();
      end
      wvalid = 1'b0; wlast = 1'b0;
      checks++; if (blocks_written !== 16'd1) begin errors++; $display("FAIL t1_blocks: got %0d want 1", blocks_written); end
      checks++; if (data_out !== '0) begin errors++; $display("FAIL t1_idle_data: got %0h want 0", data_out); end
      checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL t1_err: got %0h want 0", protocol_err); end
   endtask

   task automatic test_back_to_back();
      int prod_i = 0, cons_i = 0, model_full = 0, pulses = 0, beats_left = 0, beat_at = 0, cyc = 0;
      bit acc, stalled = 1'b0;
      do_reset();
      while (cons_i < 32 && cyc < 600) begin
         s_valid = (prod_i < 32);
         s_data  = (prod_i < 32) ? pix_tab[8 + prod_i] : '0;
         if (start_write_out === 1'b1 && beats_left == 0) begin
            pulses++; beats_left = 8; beat_at = cyc + 4;
         end
         wvalid = (beats_left > 0 && cyc >= beat_at);
         wlast  = wvalid && (beats_left == 1);
         #1;
         checks++; if (s_ready !== (model_full < 2)) begin errors++; $display("FAIL t2_ready cyc%0d: got %0h want %0h", cyc, s_ready, (model_full < 2)); end
         if (wvalid) begin
            checks++; if (data_out !== pix_tab[8 + cons_i]) begin errors++; $display("FAIL t2_beat%0d: got %0d want %0d", cons_i, data_out, pix_tab[8 + cons_i]); end
         end
         if (s_valid && !s_ready) stalled = 1'b1;
         acc = s_valid && s_ready;
         tick();
         cyc++;
         if (acc) begin prod_i++; if (prod_i % 8 == 0) model_full++; end
         if (wvalid) begin cons_i++; beats_left--; if (beats_left == 0) model_full--; end
      end
      s_valid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
      checks++; if (cons_i != 32) begin errors++; $display("FAIL t2_drained: got %0d want 32", cons_i); end
      checks++; if (pulses != 4) begin errors++; $display("FAIL t2_pulses: got %0d want 4", pulses); end
      checks++; if (stalled != 1'b1) begin errors++; $display("FAIL t2_backpressure: got %0d want 1", stalled); end
      checks++; if (blocks_written !== 16'd4) begin errors++; $display("FAIL t2_blocks: got %0d want 4", blocks_written); end
      checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL t2_err: got %0h want 0", protocol_err); end
   endtask

   task automatic test_bubbles();
      bit ok;
      int j = 0, k = 0;
      do_reset();
      fill_block(40);
      wait_pulse(ok);
      checks++; if (ok != 1'b1) begin errors++; $display("FAIL t3_pulse: got %0d want 1", ok); end
      tick();
      while (j < 8 && k < 40) begin
         wvalid = (k % 2 == 1); wlast = wvalid && (j == 7);
         checks++; if (data_out !== pix_tab[40 + j]) begin errors++; $display("FAIL t3_hold k%0d: got %0d want %0d", k, data_out, pix_tab[40 + j]); end
         tick();
         if (wvalid) j++;
         k++;
      end
      wvalid = 1'b0; wlast = 1'b0;
      checks++; if (blocks_written !== 16'd1) begin errors++; $display("FAIL t3_blocks: got %0d want 1", blocks_written); end
      checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL t3_err: got %0h want 0", protocol_err); end
   endtask

   task automatic test_early_wlast();
      bit ok;
      do_reset();
      fill_block(48);
      wait_pulse(ok);
      checks++; if (ok != 1'b1) begin errors++; $display("FAIL t4_pulse0: got %0d want 1", ok); end
      tick();
      fill_block(56);
      for (int j = 0; j < 6; j++) begin
         wvalid = 1'b1; wlast = (j == 5);
         checks++; if (data_out !== pix_tab[48 + j]) begin errors++; $display("FAIL t4_b0_beat%0d: got %0d want %0d", j, data_out, pix_tab[48 + j]); end
         tick();
      end
      wvalid = 1'b0; wlast = 1'b0;
      checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL t4_err: got %0h want 1", protocol_err); end
      checks++; if (blocks_written !== 16'd1) begin errors++; $display("FAIL t4_blocks0: got %0d want 1", blocks_written); end
      wait_pulse(ok);
      checks++; if (ok != 1'b1) begin errors++; $display("FAIL t4_pulse1: got %0d want 1", ok); end
      tick();
      for (int j = 0; j < 8; j++) begin
         wvalid = 1'b1; wlast = (j == 7);
         checks++; if (data_out !== pix_tab[56 + j]) begin errors++; $display("FAIL t4_b1_beat%0d: got %0d want %0d", j, data_out, pix_tab[56 + j]); end
         tick();
      end
      wvalid = 1'b0; wlast = 1'b0;
      checks++; if (blocks_written !== 16'd2) begin errors++; $display("FAIL t4_blocks1: got %0d want 2", blocks_written); end
      checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL t4_err_sticky: got %0h want 1", protocol_err); end
   endtask

   task automatic test_missing_wlast();
      bit ok;
      do_reset();
      fill_block(32);
      wait_pulse(ok);
      checks++; if (ok != 1'b1) begin errors++; $display("FAIL t7_pulse: got %0d want 1", ok); end
      tick();
      for (int j = 0; j < 8; j++) begin
         wvalid = 1'b1; wlast = 1'b0;
         tick();
      end
      checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL t7_err: got %0h want 1", protocol_err); end
      checks++; if (data_out !== pix_tab[39]) begin errors++; $display("FAIL t7_hold: got %0d want %0d", data_out, pix_tab[39]); end
      checks++; if (blocks_written !== 16'd0) begin errors++; $display("FAIL t7_blocks_pending: got %0d want 0", blocks_written); end
      wlast = 1'b1;
      tick();
      wvalid = 1'b0; wlast = 1'b0;
      checks++; if (blocks_written !== 16'd1) begin errors++; $display("FAIL t7_blocks: got %0d want 1", blocks_written); end
      checks++; if (data_out !== '0) begin errors++; $display("FAIL t7_idle_data: got %0h want 0", data_out); end
   endtask

   task automatic test_reset_mid_drain();
      bit ok;
      int stray = 0;
      do_reset();
      wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL t5_idle_wvalid_err: got %0h want 1", protocol_err); end
      fill_block(0);
      wait_pulse(ok);
      tick();
      drain_burst();
      checks++; if (blocks_written !== 16'd1) begin errors++; $display("FAIL t5_blocks_pre: got %0d want 1", blocks_written); end
      fill_block(8);
      wait_pulse(ok);
      checks++; if (ok != 1'b1) begin errors++; $display("FAIL t5_pulse: got %0d want 1", ok); end
      tick();
      for (int j = 0; j < 3; j++) begin
         wvalid = 1'b1; wlast = 1'b0;
         tick();
      end
      checks++; if (data_out !== pix_tab[11]) begin errors++; $display("FAIL t5_beat3: got %0d want %0d", data_out, pix_tab[11]); end
      #1 rst = 1'b1;
      #1;
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL t5_async_ready: got %0h want 0", s_ready); end
      checks++; if (data_out !== '0) begin errors++; $display("FAIL t5_async_data: got %0h want 0", data_out); end
      checks++; if (blocks_written !== 16'd0) begin errors++; $display("FAIL t5_async_blocks: got %0d want 0", blocks_written); end
      checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL t5_async_err: got %0h want 0", protocol_err); end
      checks++; if (start_write_out !== 1'b0) begin errors++; $display("FAIL t5_async_start: got %0h want 0", start_write_out); end
      wvalid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      for (int k = 0; k < 6; k++) begin
         if (start_write_out === 1'b1) stray++;
         tick();
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL t5_no_repulse: got %0d want 0", stray); end
      fill_block(16);
      wait_pulse(ok);
      checks++; if (ok != 1'b1) begin errors++; $display("FAIL t5_fresh_pulse: got %0d want 1", ok); end
      tick();
      for (int j = 0; j < 8; j++) begin
         wvalid = 1'b1; wlast = (j == 7);
         checks++; if (data_out !== pix_tab[16 + j]) begin errors++; $display("FAIL t5_fresh_beat%0d: got %0d want %0d", j, data_out, pix_tab[16 + j]); end
         tick();
      end
      wvalid = 1'b0; wlast = 1'b0;
      checks++; if (blocks_written !== 16'd1) begin errors++; $display("FAIL t5_fresh_blocks: got %0d want 1", blocks_written); end
   endtask

   task automatic test_counter_wrap();
      bit ok;
      do_reset();
      checks++; if (w_blocks !== 16'hFFFE) begin errors++; $display("FAIL t6_init: got %0h want fffe", w_blocks); end
      fill_block(24);
      wait_pulse(ok);
      checks++; if (w_start !== 1'b1) begin errors++; $display("FAIL t6_pulse: got %0h want 1", w_start); end
      tick();
      checks++; if (w_data_out !== pix_tab[24]) begin errors++; $display("FAIL t6_data0: got %0d want %0d", w_data_out, pix_tab[24]); end
      drain_burst();
      checks++; if (w_blocks !== 16'hFFFF) begin errors++; $display("FAIL t6_ffff: got %0h want ffff", w_blocks); end
      fill_block(0);
      wait_pulse(ok);
      tick();
      drain_burst();
      checks++; if (w_blocks !== 16'h0000) begin errors++; $display("FAIL t6_wrap: got %0h want 0", w_blocks); end
      checks++; if (w_err !== 1'b0) begin errors++; $display("FAIL t6_err: got %0h want 0", w_err); end
      checks++; if (blocks_written !== 16'd2) begin errors++; $display("FAIL t6_main_blocks: got %0d want 2", blocks_written); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 64; k++) pix_tab[k] = DW'((k * 73 + 29) % 256);
      pix_tab[0] = 32'd46;  pix_tab[1] = 32'd18; pix_tab[2] = 32'd253; pix_tab[3] = 32'd180;
      pix_tab[4] = 32'd124; pix_tab[5] = 32'd96; pix_tab[6] = 32'd88;  pix_tab[7] = 32'd49;
      test_reset();
      test_single_block();
      test_back_to_back();
      test_bubbles();
      test_early_wlast();
      test_missing_wlast();
      test_reset_mid_drain();
      test_counter_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
